// File: rtl/vic_pkg.sv
// vic_pkg: shared constants, FSM encoding and helpers for vic_regbank.
// Optional IRQ support is enabled with VIC_REGBANK_IRQ_EN.
package vic_pkg;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_COMMIT_BIT = 1;
  localparam int CTRL_RDSEL_BIT  = 2;
  localparam int CTRL_IRQCLR_BIT = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } vic_state_e;

  // The control register sits at the top of the address space.
  function automatic int ctrl_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/vic_regbank_ctrl.sv
// vic_regbank_ctrl: CTRL register, commit FSM and optional sticky IRQ.
// Macro VIC_REGBANK_IRQ_EN adds the irq output and CTRL bit3.
module vic_regbank_ctrl
  import vic_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              frame_sync,
  output logic              copy,
  output logic              enable,
  output logic              rdsel,
  output logic              pending,
  output logic [DATA_W-1:0] rdata
`ifdef VIC_REGBANK_IRQ_EN
  ,output logic             irq
`endif
);

  vic_state_e state_q, state_d;
  logic       enable_q, enable_d;
  logic       rdsel_q, rdsel_d;
  logic [3:0] wlo;
  logic [3:0] rd4;
  logic       irq_bit;

  // Low CTRL bits of the write data, safe for any DATA_W >= 3.
  always_comb begin
    wlo = '0;
    for (int i = 0; i < 4 && i < DATA_W; i++) begin
      wlo[i] = wdata[i];
    end
  end

  // A copy only fires from PENDING; a sync seen in IDLE is dropped.
  assign copy    = (state_q == PENDING) && frame_sync;
  assign pending = (state_q == PENDING);
  assign enable  = enable_q;
  assign rdsel   = rdsel_q;

  // Next-state for the commit FSM and the R/W control bits.
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    rdsel_d  = rdsel_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_we && wlo[CTRL_COMMIT_BIT]) state_d = PENDING;
      end
      PENDING: begin
        if (frame_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (ctrl_we) begin
      enable_d = wlo[CTRL_ENABLE_BIT];
      rdsel_d  = wlo[CTRL_RDSEL_BIT];
    end
  end

  // Commit FSM and control bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      rdsel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      rdsel_q  <= rdsel_d;
    end
  end

`ifdef VIC_REGBANK_IRQ_EN
  logic irq_q, irq_d;

  // Sticky IRQ: a copy sets it and wins over a same-cycle clear.
  always_comb begin
    irq_d = irq_q;
    if (copy) begin
      irq_d = 1'b1;
    end else if (ctrl_we && wlo[CTRL_IRQCLR_BIT]) begin
      irq_d = 1'b0;
    end
  end

  // IRQ flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq     = irq_q;
  assign irq_bit = irq_q;
`else
  logic unused_irqclr;
  assign unused_irqclr = wlo[CTRL_IRQCLR_BIT];
  assign irq_bit       = 1'b0;
`endif

  // CTRL readback; COMMIT reads as the pending flag.
  always_comb begin
    rd4                  = '0;
    rd4[CTRL_ENABLE_BIT] = enable_q;
    rd4[CTRL_COMMIT_BIT] = (state_q == PENDING);
    rd4[CTRL_RDSEL_BIT]  = rdsel_q;
    rd4[CTRL_IRQCLR_BIT] = irq_bit;
    rdata                = DATA_W'(rd4);
  end

endmodule

// File: rtl/vic_regbank.sv
// vic_regbank: double-buffered VIC register file, frame-aligned commit.
// Macro VIC_REGBANK_IRQ_EN adds the o_irq output.
module vic_regbank
  import vic_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 31,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          i_VIC_regaddr,
  input  logic [DATA_W-1:0]          i_VIC_data,
  input  logic                       i_VIC_we,
  input  logic                       i_VIC_re,
  input  logic                       i_frame_sync,
  output logic [DATA_W-1:0]          o_VIC_data,
  output logic                       o_rd_valid,
  output logic [NUM_REGS*DATA_W-1:0] o_buffer,
  output logic                       o_enable,
  output logic                       o_pending
`ifdef VIC_REGBANK_IRQ_EN
  ,output logic                      o_irq
`endif
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(ctrl_addr(ADDR_W));

  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] active_q [NUM_REGS];
  logic [DATA_W-1:0] active_d [NUM_REGS];
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_mux;
  logic [DATA_W-1:0] ctrl_rdata;
  logic              ctrl_we;
  logic              copy;
  logic              rdsel;

  assign ctrl_we = i_VIC_we && (i_VIC_regaddr == CTRL_ADDR);

  vic_regbank_ctrl #(
    .DATA_W (DATA_W)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .ctrl_we    (ctrl_we),
    .wdata      (i_VIC_data),
    .frame_sync (i_frame_sync),
    .copy       (copy),
    .enable     (o_enable),
    .rdsel      (rdsel),
    .pending    (o_pending),
    .rdata      (ctrl_rdata)
`ifdef VIC_REGBANK_IRQ_EN
    ,.irq       (o_irq)
`endif
  );

  // Host writes go to shadow; copy snapshots the pre-write shadow.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      shadow_d[k] = shadow_q[k];
      active_d[k] = copy ? shadow_q[k] : active_q[k];
      if (i_VIC_we && (i_VIC_regaddr == ADDR_W'(k))) begin
        shadow_d[k] = i_VIC_data;
      end
    end
  end

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_VIC_regaddr == ADDR_W'(k)) begin
        rd_mux = rdsel ? active_q[k] : shadow_q[k];
      end
    end
    if (i_VIC_regaddr == CTRL_ADDR) rd_mux = ctrl_rdata;
  end

  // Read data holds its last value when no read is issued.
  always_comb begin
    rd_valid_d = i_VIC_re;
    rdata_d    = i_VIC_re ? rd_mux : rdata_q;
  end

  // Bank storage and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Flatten the active bank for the render pipeline.
  always_comb begin
    o_buffer = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_buffer[k*DATA_W +: DATA_W] = active_q[k];
    end
  end

  assign o_VIC_data = rdata_q;
  assign o_rd_valid = rd_valid_q;

endmodule
